// File: rtl/delay_gen_pkg.sv
// Shared types for the multi-channel enable sequencer.
// Channel FSM encoding is kept here so the top and channel agree on state names.
package delay_gen_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        WAIT_ON  = 2'd1,
        ON       = 2'd2,
        WAIT_OFF = 2'd3
    } dg_state_e;

endpackage

// File: rtl/delay_gen_mc_if.sv
// Per-channel enable request / delay programming / delayed-enable bundle.
// The controller side uses master, the sequencer uses slave.
interface delay_gen_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH*CNT_W-1:0] dly_on_i;
    logic [NUM_CH*CNT_W-1:0] dly_off_i;
    logic [NUM_CH-1:0]       en_o;
    logic [NUM_CH-1:0]       busy_o;

    modport master (
        output en_i,
        output dly_on_i,
        output dly_off_i,
        input  en_o,
        input  busy_o
    );

    modport slave (
        input  en_i,
        input  dly_on_i,
        input  dly_off_i,
        output en_o,
        output busy_o
    );
endinterface

// File: rtl/delay_gen_ch.sv
// One sequencer channel: delays rise and fall of i_en by a tick count
// captured when the channel enters WAIT_ON or WAIT_OFF.
module delay_gen_ch
    import delay_gen_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_tick,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_dly_on,
    input  logic [CNT_W-1:0] i_dly_off,
    output logic             o_en,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dg_state_e        r_state;
    dg_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= OFF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Ticks are ignored on the entry cycle: only WAIT_* states consume them.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            OFF: begin
                if (i_en) begin
                    if (i_dly_on == '0) begin
                        w_state_nxt = ON;
                    end else begin
                        w_state_nxt = WAIT_ON;
                        w_cnt_nxt   = i_dly_on;
                    end
                end
            end
            WAIT_ON: begin
                if (!i_en) begin
                    w_state_nxt = OFF;
                    w_cnt_nxt   = '0;
                end else if (i_tick) begin
                    w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CNT_ONE;
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = ON;
                    end
                end
            end
            ON: begin
                if (!i_en) begin
                    if (i_dly_off == '0) begin
                        w_state_nxt = OFF;
                    end else begin
                        w_state_nxt = WAIT_OFF;
                        w_cnt_nxt   = i_dly_off;
                    end
                end
            end
            WAIT_OFF: begin
                if (i_en) begin
                    w_state_nxt = ON;
                    w_cnt_nxt   = '0;
                end else if (i_tick) begin
                    w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CNT_ONE;
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt = OFF;
                    end
                end
            end
            default: begin
                w_state_nxt = OFF;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_en   = (r_state == ON) || (r_state == WAIT_OFF);
    assign o_busy = (r_state == WAIT_ON) || (r_state == WAIT_OFF);

endmodule

// File: rtl/delay_gen_mc.sv
// Multi-channel enable sequencer: synchronises the async rtc_i tick source
// and fans a single-cycle tick out to independent channel FSMs.
module delay_gen_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              rtc_i,
    delay_gen_mc_if.slave     bus
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   w_tick;
    logic [NUM_CH-1:0]      w_en;
    logic [NUM_CH-1:0]      w_busy;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_sync <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rtc_i};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick = r_sync[SYNC_STAGES-1] & ~r_edge;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        delay_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .i_clk     (clk_i),
            .i_arst    (arst_i),
            .i_tick    (w_tick),
            .i_en      (bus.en_i[g]),
            .i_dly_on  (bus.dly_on_i[g*CNT_W +: CNT_W]),
            .i_dly_off (bus.dly_off_i[g*CNT_W +: CNT_W]),
            .o_en      (w_en[g]),
            .o_busy    (w_busy[g])
        );
    end

    assign bus.en_o   = w_en;
    assign bus.busy_o = w_busy;

endmodule

// File: tb/tb_delay_gen_mc.sv
// Directed bench for delay_gen_mc: rtc_i pulses are driven by hand so every
// expected en_o/busy_o value can be written down cycle-exactly.
module tb_delay_gen_mc;

    logic clk;
    logic arst;
    logic rtc;
    int   nChecks;
    int   nPass;

    delay_gen_mc_if #(.NUM_CH(4), .CNT_W(8)) ifc ();

    delay_gen_mc #(
        .NUM_CH      (4),
        .CNT_W       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .rtc_i  (rtc),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expEn, input logic [3:0] expBusy);
        nChecks++;
        assert ({ifc.en_o, ifc.busy_o} === {expEn, expBusy}) nPass++;
        else $error("[TB] FAIL %s: got en_o=%h busy_o=%h, expected en_o=%h busy_o=%h",
                    tag, ifc.en_o, ifc.busy_o, expEn, expBusy);
    endtask

    task automatic applyStimulus(input logic [3:0] en);
        ifc.en_i = en;
    endtask

    task automatic setDly(input int ch, input logic [7:0] dOn, input logic [7:0] dOff);
        ifc.dly_on_i[ch*8 +: 8]  = dOn;
        ifc.dly_off_i[ch*8 +: 8] = dOff;
    endtask

    task automatic rtcPulse();
        rtc = 1'b1;
        stepClk(10);
        rtc = 1'b0;
        stepClk(10);
    endtask

    // Tick reaches the FSMs on the 3rd rising edge after rtc rises.
    task automatic tickCheck(input string tag, input logic [3:0] preEn, input logic [3:0] preBusy,
                             input logic [3:0] postEn, input logic [3:0] postBusy);
        rtc = 1'b1;
        stepClk(2);
        checkOutput({tag, "_pre"}, preEn, preBusy);
        stepClk(1);
        checkOutput({tag, "_post"}, postEn, postBusy);
        stepClk(7);
        rtc = 1'b0;
        stepClk(10);
    endtask

    initial begin
        nChecks       = 0;
        nPass         = 0;
        arst          = 1'b1;
        rtc           = 1'b0;
        ifc.en_i      = 4'hF;
        ifc.dly_on_i  = '0;
        ifc.dly_off_i = '0;
        for (int k = 0; k < 4; k++) setDly(k, 8'd2, 8'd0);

        stepClk(1);
        checkOutput("rst_hold", 4'h0, 4'h0);
        rtcPulse();
        checkOutput("rst_tick1", 4'h0, 4'h0);
        rtcPulse();
        checkOutput("rst_tick2", 4'h0, 4'h0);

        arst = 1'b0;
        stepClk(1);
        checkOutput("rel_wait", 4'h0, 4'hF);
        rtcPulse();
        checkOutput("rel_tick1", 4'h0, 4'hF);
        tickCheck("rel_tick2", 4'h0, 4'hF, 4'hF, 4'h0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("rel_off", 4'h0, 4'h0);
        for (int k = 0; k < 4; k++) setDly(k, 8'd0, 8'd0);

        $display("[TB] ch0 on=10 off=3");
        setDly(0, 8'd10, 8'd3);
        applyStimulus(4'h1);
        stepClk(1);
        checkOutput("ch0_waiton", 4'h0, 4'h1);
        repeat (9) rtcPulse();
        checkOutput("ch0_tick9", 4'h0, 4'h1);
        tickCheck("ch0_tick10", 4'h0, 4'h1, 4'h1, 4'h0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch0_waitoff", 4'h1, 4'h1);
        repeat (2) rtcPulse();
        checkOutput("ch0_off2", 4'h1, 4'h1);
        tickCheck("ch0_off3", 4'h1, 4'h1, 4'h0, 4'h0);

        $display("[TB] ch1 zero delays");
        applyStimulus(4'h2);
        checkOutput("ch1_pre", 4'h0, 4'h0);
        stepClk(1);
        checkOutput("ch1_rise", 4'h2, 4'h0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch1_fall", 4'h0, 4'h0);

        $display("[TB] ch2 cancel/abort");
        setDly(2, 8'd10, 8'd2);
        applyStimulus(4'h4);
        stepClk(1);
        checkOutput("ch2_waiton", 4'h0, 4'h4);
        repeat (4) rtcPulse();
        checkOutput("ch2_tick4", 4'h0, 4'h4);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch2_cancel", 4'h0, 4'h0);
        applyStimulus(4'h4);
        stepClk(1);
        checkOutput("ch2_rewait", 4'h0, 4'h4);
        repeat (9) rtcPulse();
        checkOutput("ch2_retick9", 4'h0, 4'h4);
        tickCheck("ch2_retick10", 4'h0, 4'h4, 4'h4, 4'h0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch2_waitoff", 4'h4, 4'h4);
        rtcPulse();
        checkOutput("ch2_off1", 4'h4, 4'h4);
        applyStimulus(4'h4);
        stepClk(1);
        checkOutput("ch2_abort", 4'h4, 4'h0);
        repeat (3) rtcPulse();
        checkOutput("ch2_hold", 4'h4, 4'h0);
        setDly(2, 8'd0, 8'd0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch2_off", 4'h0, 4'h0);

        $display("[TB] ch3 reprogram and max delay");
        setDly(3, 8'd5, 8'd0);
        applyStimulus(4'h8);
        stepClk(1);
        checkOutput("ch3_waiton", 4'h0, 4'h8);
        repeat (2) rtcPulse();
        setDly(3, 8'd20, 8'd0);
        repeat (2) rtcPulse();
        checkOutput("ch3_tick4", 4'h0, 4'h8);
        tickCheck("ch3_tick5", 4'h0, 4'h8, 4'h8, 4'h0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch3_off", 4'h0, 4'h0);
        setDly(3, 8'd255, 8'd0);
        applyStimulus(4'h8);
        stepClk(1);
        checkOutput("ch3_max_wait", 4'h0, 4'h8);
        repeat (254) rtcPulse();
        checkOutput("ch3_tick254", 4'h0, 4'h8);
        tickCheck("ch3_tick255", 4'h0, 4'h8, 4'h8, 4'h0);
        repeat (2) rtcPulse();
        checkOutput("ch3_nowrap", 4'h8, 4'h0);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ch3_off2", 4'h0, 4'h0);

        $display("[TB] all channels together");
        for (int k = 0; k < 4; k++) setDly(k, 8'(k + 1), 8'd0);
        rtc = 1'b1;
        stepClk(2);
        applyStimulus(4'hF);
        stepClk(1);
        checkOutput("all_coincide", 4'h0, 4'hF);
        stepClk(7);
        rtc = 1'b0;
        stepClk(10);
        tickCheck("all_t1", 4'h0, 4'hF, 4'h1, 4'hE);
        tickCheck("all_t2", 4'h1, 4'hE, 4'h3, 4'hC);
        tickCheck("all_t3", 4'h3, 4'hC, 4'h7, 4'h8);
        tickCheck("all_t4", 4'h7, 4'h8, 4'hF, 4'h0);

        $display("[TB] async reset mid-count");
        for (int k = 0; k < 4; k++) setDly(k, 8'd0, 8'd5);
        applyStimulus(4'h0);
        stepClk(1);
        checkOutput("ar_waitoff", 4'hF, 4'hF);
        rtcPulse();
        #2 arst = 1'b1;
        #1 checkOutput("ar_async", 4'h0, 4'h0);
        stepClk(1);
        arst = 1'b0;
        stepClk(2);
        checkOutput("ar_after", 4'h0, 4'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
